// File: rtl/conversor_pkg.sv
// Shared definitions for the code-to-BCD conversion controller.
// The optional self-test FSM state is present only when CONVERSOR_SELFTEST_EN is defined.
package conversor_pkg;

`ifdef CONVERSOR_SELFTEST_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_HOLD, ST_TEST} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_HOLD} state_t;
`endif

    // The only code words {H,G,F,E} that map to a decimal digit, in digit order
    localparam logic [3:0] CODE_0 = 4'b0000;
    localparam logic [3:0] CODE_1 = 4'b0001;
    localparam logic [3:0] CODE_2 = 4'b0011;
    localparam logic [3:0] CODE_3 = 4'b0100;
    localparam logic [3:0] CODE_4 = 4'b0101;
    localparam logic [3:0] CODE_5 = 4'b0111;
    localparam logic [3:0] CODE_6 = 4'b1001;
    localparam logic [3:0] CODE_7 = 4'b1011;
    localparam logic [3:0] CODE_8 = 4'b1100;
    localparam logic [3:0] CODE_9 = 4'b1101;

    localparam int NUM_DIGITS = 10;

    // Digit reported for codes outside the map
    localparam logic [3:0] ERR_BCD_DEFAULT = 4'hF;

endpackage

// File: rtl/conversor_map.sv
// Combinational code word -> BCD digit mapper with invalid-code flag.
module conversor_map
    import conversor_pkg::*;
#(
    parameter logic [3:0] ERR_BCD = ERR_BCD_DEFAULT
) (
    input  logic [3:0] code,
    output logic [3:0] bcd,
    output logic       err
);

    // Table lookup; anything not listed is an invalid code
    always_comb begin
        bcd = ERR_BCD;
        err = 1'b1;
        case (code)
            CODE_0:  begin bcd = 4'd0; err = 1'b0; end
            CODE_1:  begin bcd = 4'd1; err = 1'b0; end
            CODE_2:  begin bcd = 4'd2; err = 1'b0; end
            CODE_3:  begin bcd = 4'd3; err = 1'b0; end
            CODE_4:  begin bcd = 4'd4; err = 1'b0; end
            CODE_5:  begin bcd = 4'd5; err = 1'b0; end
            CODE_6:  begin bcd = 4'd6; err = 1'b0; end
            CODE_7:  begin bcd = 4'd7; err = 1'b0; end
            CODE_8:  begin bcd = 4'd8; err = 1'b0; end
            CODE_9:  begin bcd = 4'd9; err = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/conversor_ctrl.sv
// Handshaked sequencing controller around conversor_map.
// Flow: IDLE (accept word) -> CONV (register mapper result) -> HOLD (offer result).
// Optional built-in self-test sweep enabled by defining CONVERSOR_SELFTEST_EN.
module conversor_ctrl
    import conversor_pkg::*;
#(
    parameter int         CNT_W   = 8,
    parameter logic [3:0] ERR_BCD = ERR_BCD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_bcd,
    output logic             out_err,
    output logic [CNT_W-1:0] conv_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
`ifdef CONVERSOR_SELFTEST_EN
    ,
    input  logic             start_test,
    output logic             test_done,
    output logic             test_pass
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] conv_q, conv_d;
    logic [CNT_W-1:0] errc_q, errc_d;

    logic [3:0]       map_in;
    logic [3:0]       map_bcd;
    logic             map_err;

`ifdef CONVERSOR_SELFTEST_EN
    localparam logic [3:0] DIGITS = 4'(NUM_DIGITS);

    logic [3:0] idx_q, idx_d;   // code currently swept
    logic [3:0] exp_q, exp_d;   // next digit expected in ascending order
    logic       ok_q, ok_d;     // no ordering violation seen so far
    logic       done_q, done_d;
    logic       pass_q, pass_d;
`endif

    conversor_map #(.ERR_BCD(ERR_BCD)) u_map (
        .code (map_in),
        .bcd  (map_bcd),
        .err  (map_err)
    );

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
            conv_q  <= '0;
            errc_q  <= '0;
`ifdef CONVERSOR_SELFTEST_EN
            idx_q   <= '0;
            exp_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
            errc_q  <= errc_d;
`ifdef CONVERSOR_SELFTEST_EN
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`endif
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        conv_d  = conv_q;
        errc_d  = errc_q;
`ifdef CONVERSOR_SELFTEST_EN
        idx_d   = idx_q;
        exp_d   = exp_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef CONVERSOR_SELFTEST_EN
                // Self-test request wins over a pending word
                if (start_test) begin
                    state_d = ST_TEST;
                    idx_d   = '0;
                    exp_d   = '0;
                    ok_d    = 1'b1;
                    pass_d  = 1'b0;
                end else
`endif
                if (in_valid) begin
                    code_d  = in_code;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d   = map_bcd;
                err_d   = map_err;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    if (err_q) begin
                        if (errc_q != CNT_MAX) errc_d = errc_q + CNT_W'(1);
                    end else begin
                        if (conv_q != CNT_MAX) conv_d = conv_q + CNT_W'(1);
                    end
                end
            end
`ifdef CONVERSOR_SELFTEST_EN
            ST_TEST: begin
                idx_d = idx_q + 4'd1;
                if (!map_err) begin
                    if ((map_bcd == exp_q) && (exp_q < DIGITS)) exp_d = exp_q + 4'd1;
                    else                                         ok_d  = 1'b0;
                end
                if (idx_q == 4'd15) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pass_d  = ok_d && (exp_d == DIGITS);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs and mapper input selection
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !reset;
        out_valid = (state_q == ST_HOLD);
        busy      = (state_q != ST_IDLE);
        map_in    = code_q;
`ifdef CONVERSOR_SELFTEST_EN
        if (start_test) in_ready = 1'b0;
        if (state_q == ST_TEST) map_in = idx_q;
`endif
    end

    assign out_bcd    = bcd_q;
    assign out_err    = err_q;
    assign conv_count = conv_q;
    assign err_count  = errc_q;
`ifdef CONVERSOR_SELFTEST_EN
    assign test_done  = done_q;
    assign test_pass  = pass_q;
`endif

endmodule
